// File: rtl/arb_pkg.sv
// Shared types and sizes for the 16-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned NUM_REQ = 16;
    localparam int unsigned IDX_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_RELEASE
    } arb_state_t;

endpackage

// File: rtl/rr_pick16.sv
// Rotating-priority picker: first set request at or after ptr, wrapping past 15.
module rr_pick16
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Scan ptr, ptr+1, ... with 4-bit wraparound and keep the first hit.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[ptr + IDX_W'(i)]) begin
                idx = ptr + IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for 16 requesters with done/drop/timeout release.
module rr_arbiter_16
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld,
    output logic               timeout
);

    localparam int unsigned HC_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HC_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HC_W'(MAX_HOLD - 1);
    localparam logic            HOLD_EN   = (MAX_HOLD != 0);

    arb_state_t          state;
    logic [IDX_W-1:0]    ptr;
    logic [HC_W-1:0]     hold_cnt;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic                own_req;
    logic                hold_hit;
    logic                grant_exit;

    rr_pick16 u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Release conditions evaluated while a grant is active.
    assign own_req    = req[gnt_idx];
    assign hold_hit   = HOLD_EN && (hold_cnt == HOLD_LAST);
    assign grant_exit = done || !own_req || hold_hit;

    // Arbiter FSM with pointer, hold counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_idx  <= '0;
            gnt_vld  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        state    <= ST_GRANT;
                        gnt_idx  <= pick_idx;
                        gnt_vld  <= 1'b1;
                        gnt      <= NUM_REQ'(1) << pick_idx;
                        hold_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (grant_exit) begin
                        state    <= ST_RELEASE;
                        gnt      <= '0;
                        gnt_vld  <= 1'b0;
                        ptr      <= gnt_idx + IDX_W'(1);
                        hold_cnt <= '0;
                        // done or a dropped request in the limit cycle suppresses the pulse
                        timeout  <= hold_hit && !done && own_req;
                    end else begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                    end
                end
                ST_RELEASE: begin
                    state    <= ST_IDLE;
                    hold_cnt <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed bench for rr_arbiter_16 (built with MAX_HOLD=4).
module tb_rr_arbiter_16;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_vld;
    logic        timeout;

    int n_cmp;
    int n_fail;

    rr_arbiter_16 #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Short reset pulse placed between clock edges.
    task automatic do_reset();
        req   = '0;
        done  = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [21:0] obs;
        req   = 16'hFFFF;
        done  = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            step();
            obs = {gnt, gnt_idx, gnt_vld, timeout};
            n_cmp++;
            if (obs !== 22'h0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got %h/%0d/%b/%b want 0000/0/0/0", i, gnt, gnt_idx, gnt_vld, timeout);
            end
        end
        req   = '0;
        rst_n = 1'b1;
        step();
        obs = {gnt, gnt_idx, gnt_vld, timeout};
        n_cmp++;
        if (obs !== 22'h0) begin
            n_fail++;
            $display("FAIL reset_idle: got %h/%0d/%b/%b want 0000/0/0/0", gnt, gnt_idx, gnt_vld, timeout);
        end
    endtask

    task automatic test_single();
        logic [21:0] obs;
        logic [21:0] exp;
        do_reset();
        req = 16'h0010;
        exp = {16'h0010, 4'd4, 1'b1, 1'b0};
        for (int i = 1; i <= 3; i++) begin
            step();
            obs = {gnt, gnt_idx, gnt_vld, timeout};
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL single_grant[N+%0d]: got %h/%0d/%b/%b want 0010/4/1/0", i, gnt, gnt_idx, gnt_vld, timeout);
            end
        end
        done = 1'b1;
        step();
        done = 1'b0;
        exp  = {16'h0000, 4'd4, 1'b0, 1'b0};
        obs  = {gnt, gnt_idx, gnt_vld, timeout};
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL single_release: got %h/%0d/%b/%b want 0000/4/0/0", gnt, gnt_idx, gnt_vld, timeout);
        end
        step();
        obs = {gnt, gnt_idx, gnt_vld, timeout};
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL single_dead_cycle: got %h/%0d/%b/%b want 0000/4/0/0", gnt, gnt_idx, gnt_vld, timeout);
        end
        // ptr is now 5, so of requesters 4 and 5 the 5 wins
        req = 16'h0030;
        step();
        exp = {16'h0020, 4'd5, 1'b1, 1'b0};
        obs = {gnt, gnt_idx, gnt_vld, timeout};
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL single_ptr5: got %h/%0d/%b/%b want 0020/5/1/0", gnt, gnt_idx, gnt_vld, timeout);
        end
        req = '0;
        step();
        step();
    endtask

    task automatic test_fairness();
        logic [21:0] obs;
        logic [3:0]  order [4] = '{4'd0, 4'd15, 4'd0, 4'd15};
        logic [15:0] onehot [4] = '{16'h0001, 16'h8000, 16'h0001, 16'h8000};
        do_reset();
        req = 16'h8001;
        for (int g = 0; g < 4; g++) begin
            step();
            obs = {gnt, gnt_idx, gnt_vld, timeout};
            n_cmp++;
            if (obs !== {onehot[g], order[g], 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %h/%0d/%b/%b want %h/%0d/1/0", g, gnt, gnt_idx, gnt_vld, timeout, onehot[g], order[g]);
            end
            done = 1'b1;
            step();
            done = 1'b0;
            obs = {gnt, gnt_idx, gnt_vld, timeout};
            n_cmp++;
            if (obs !== {16'h0000, order[g], 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL rr_release[%0d]: got %h/%0d/%b/%b want 0000/%0d/0/0", g, gnt, gnt_idx, gnt_vld, timeout, order[g]);
            end
            step();
        end
        step();
        obs = {gnt, gnt_idx, gnt_vld, timeout};
        n_cmp++;
        if (obs !== {16'h0001, 4'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL rr_wrap: got %h/%0d/%b/%b want 0001/0/1/0", gnt, gnt_idx, gnt_vld, timeout);
        end
        req = '0;
        step();
        step();
    endtask

    task automatic test_timeout();
        logic [21:0] obs;
        do_reset();
        req = 16'h0004;
        for (int i = 0; i < 4; i++) begin
            step();
            obs = {gnt, gnt_idx, gnt_vld, timeout};
            n_cmp++;
            if (obs !== {16'h0004, 4'd2, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL tmo_hold[%0d]: got %h/%0d/%b/%b want 0004/2/1/0", i, gnt, gnt_idx, gnt_vld, timeout);
            end
        end
        step();
        obs = {gnt, gnt_idx, gnt_vld, timeout};
        n_cmp++;
        if (obs !== {16'h0000, 4'd2, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL tmo_pulse: got %h/%0d/%b/%b want 0000/2/0/1", gnt, gnt_idx, gnt_vld, timeout);
        end
        step();
        obs = {gnt, gnt_idx, gnt_vld, timeout};
        n_cmp++;
        if (obs !== {16'h0000, 4'd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL tmo_pulse_end: got %h/%0d/%b/%b want 0000/2/0/0", gnt, gnt_idx, gnt_vld, timeout);
        end
        step();
        obs = {gnt, gnt_idx, gnt_vld, timeout};
        n_cmp++;
        if (obs !== {16'h0004, 4'd2, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL tmo_regrant: got %h/%0d/%b/%b want 0004/2/1/0", gnt, gnt_idx, gnt_vld, timeout);
        end
        req = '0;
        step();
        step();
    endtask

    task automatic test_collision();
        logic [21:0] obs;
        do_reset();
        req = 16'h0008;
        for (int i = 0; i < 4; i++) step();
        done = 1'b1;
        step();
        done = 1'b0;
        obs = {gnt, gnt_idx, gnt_vld, timeout};
        n_cmp++;
        if (obs !== {16'h0000, 4'd3, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL col_done_at_limit: got %h/%0d/%b/%b want 0000/3/0/0", gnt, gnt_idx, gnt_vld, timeout);
        end
        step();
        req  = '0;
        done = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            obs = {gnt, gnt_idx, gnt_vld, timeout};
            n_cmp++;
            if (obs !== {16'h0000, 4'd3, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL col_done_idle[%0d]: got %h/%0d/%b/%b want 0000/3/0/0", i, gnt, gnt_idx, gnt_vld, timeout);
            end
        end
        done = 1'b0;
        req  = 16'h0008;
        step();
        obs = {gnt, gnt_idx, gnt_vld, timeout};
        n_cmp++;
        if (obs !== {16'h0008, 4'd3, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL col_regrant: got %h/%0d/%b/%b want 0008/3/1/0", gnt, gnt_idx, gnt_vld, timeout);
        end
        for (int i = 0; i < 3; i++) step();
        req = '0;
        step();
        obs = {gnt, gnt_idx, gnt_vld, timeout};
        n_cmp++;
        if (obs !== {16'h0000, 4'd3, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL col_drop_at_limit: got %h/%0d/%b/%b want 0000/3/0/0", gnt, gnt_idx, gnt_vld, timeout);
        end
        step();
    endtask

    task automatic test_reset_mid_grant();
        logic [21:0] obs;
        do_reset();
        req = 16'h0200;
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        step();
        obs = {gnt, gnt_idx, gnt_vld, timeout};
        n_cmp++;
        if (obs !== {16'h0200, 4'd9, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_pre_grant: got %h/%0d/%b/%b want 0200/9/1/0", gnt, gnt_idx, gnt_vld, timeout);
        end
        #3;
        rst_n = 1'b0;
        #1;
        obs = {gnt, gnt_idx, gnt_vld, timeout};
        n_cmp++;
        if (obs !== 22'h0) begin
            n_fail++;
            $display("FAIL mid_async_clear: got %h/%0d/%b/%b want 0000/0/0/0", gnt, gnt_idx, gnt_vld, timeout);
        end
        // bit 12 would win if ptr had kept its pre-reset value of 10
        req = 16'h1201;
        step();
        obs = {gnt, gnt_idx, gnt_vld, timeout};
        n_cmp++;
        if (obs !== 22'h0) begin
            n_fail++;
            $display("FAIL mid_in_reset: got %h/%0d/%b/%b want 0000/0/0/0", gnt, gnt_idx, gnt_vld, timeout);
        end
        rst_n = 1'b1;
        step();
        obs = {gnt, gnt_idx, gnt_vld, timeout};
        n_cmp++;
        if (obs !== {16'h0001, 4'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_post_reset_grant: got %h/%0d/%b/%b want 0001/0/1/0", gnt, gnt_idx, gnt_vld, timeout);
        end
        req = '0;
        step();
        step();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        req    = '0;
        done   = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_collision();
        test_reset_mid_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
